cache_phy_wb_bridge: RTL and testbench

//  Downstream of cache_ctrl: consumes its phy_vld/phy_rdy/phy_cmd[34:0] command stream.

---
 rtl/cache_phy_wb_bridge.sv | 147 ++++++++++++++
 tb/tb_cache_phy_wb_bridge.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/cache_phy_wb_bridge.sv
// Bridges the cache_ctrl phy command stream onto single-beat Wishbone B4 classic cycles.
// Optional build macro CACHE_PHY_TIMEOUT_EN adds a bus watchdog limited by TIMEOUT_CYC.
module cache_phy_wb_bridge #(
  parameter int FIFO_DEPTH  = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        phy_vld_i,
  output logic        phy_rdy_o,
  input  logic [34:0] phy_cmd_i,
  input  logic [31:0] phy_wdat_i,
  output logic        phy_ack_o,
  output logic [31:0] phy_rdat_o,
  output logic        phy_err_o,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [31:0] wb_adr_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i
);
  // state | meaning
  // IDLE  | no transaction, waiting for a queued command
  // BUS   | cyc/stb asserted, waiting for slave ack/err (or watchdog)
  // RESP  | one-cycle phy_ack with captured read data / error
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int EW = 67;

  state_t        state, state_nxt;
  logic [EW-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [EW-1:0] head;
  logic          push, pop, empty, full_nxt, rdy_q;
  logic          done, err_nxt, err_q, to_hit;
  logic [31:0]   rdat_nxt, rdat_q;

  assign push       = phy_vld_i & rdy_q;
  assign empty      = (wr_ptr == rd_ptr);
  assign wr_ptr_nxt = wr_ptr + (AW+1)'(push);
  assign rd_ptr_nxt = rd_ptr + (AW+1)'(pop);
  assign full_nxt   = (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                      (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);
  assign head       = fifo_mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= {phy_cmd_i, phy_wdat_i};
  end

`ifdef CACHE_PHY_TIMEOUT_EN
  logic [15:0] to_cnt;

  // Cleared by the pop that enters BUS, so the first BUS cycle sees 0.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)           to_cnt <= '0;
    else if (pop)           to_cnt <= '0;
    else if (state == BUS)  to_cnt <= to_cnt + 16'd1;
  end

  assign to_hit = (state == BUS) && (to_cnt == 16'(TIMEOUT_CYC - 1));
`else
  logic to_cfg_unused;
  assign to_cfg_unused = |TIMEOUT_CYC;
  assign to_hit        = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    done      = 1'b0;
    err_nxt   = 1'b0;
    rdat_nxt  = wb_dat_i;
    case (state)
      IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = BUS;
        end
      end
      BUS: begin
        if (wb_ack_i | wb_err_i) begin
          done      = 1'b1;
          err_nxt   = wb_err_i;
          state_nxt = RESP;
        end else if (to_hit) begin
          done      = 1'b1;
          err_nxt   = 1'b1;
          rdat_nxt  = 32'hDEAD_BEEF;
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = BUS;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      rdy_q    <= 1'b0;
      wb_we_o  <= 1'b0;
      wb_adr_o <= '0;
      wb_sel_o <= '0;
      wb_dat_o <= '0;
      rdat_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state  <= state_nxt;
      wr_ptr <= wr_ptr_nxt;
      rd_ptr <= rd_ptr_nxt;
      rdy_q  <= !full_nxt;
      if (pop) begin
        wb_we_o  <= head[66];
        wb_sel_o <= head[66] ? head[65:62] : 4'hF;
        wb_adr_o <= {head[61:32], 2'b00};
        wb_dat_o <= head[31:0];
      end
      if (done) begin
        rdat_q <= rdat_nxt;
        err_q  <= err_nxt;
      end
    end
  end

  // Decoded from the state register so reset drops cyc/stb without waiting for a clock.
  assign wb_cyc_o   = (state == BUS);
  assign wb_stb_o   = (state == BUS);
  assign phy_rdy_o  = rdy_q;
  assign phy_ack_o  = (state == RESP);
  assign phy_rdat_o = phy_ack_o ? rdat_q : 32'h0;
  assign phy_err_o  = phy_ack_o & err_q;

endmodule

// File: tb/tb_cache_phy_wb_bridge.sv
// Directed self-checking bench for cache_phy_wb_bridge; define CACHE_PHY_TIMEOUT_EN to
// also exercise the watchdog with TIMEOUT_CYC=8.
module tb_cache_phy_wb_bridge;
`ifdef CACHE_PHY_TIMEOUT_EN
  localparam int TO = 8;
`else
  localparam int TO = 255;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        phy_vld_i;
  logic        phy_rdy_o;
  logic [34:0] phy_cmd_i;
  logic [31:0] phy_wdat_i;
  logic        phy_ack_o;
  logic [31:0] phy_rdat_o;
  logic        phy_err_o;
  logic        wb_cyc_o, wb_stb_o, wb_we_o;
  logic [31:0] wb_adr_o;
  logic [3:0]  wb_sel_o;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack_i, wb_err_i;

  int errors = 0;
  int checks = 0;
  int ack_cnt;

  cache_phy_wb_bridge #(.FIFO_DEPTH(2), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .phy_vld_i(phy_vld_i), .phy_rdy_o(phy_rdy_o), .phy_cmd_i(phy_cmd_i),
    .phy_wdat_i(phy_wdat_i), .phy_ack_o(phy_ack_o), .phy_rdat_o(phy_rdat_o),
    .phy_err_o(phy_err_o), .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o),
    .wb_we_o(wb_we_o), .wb_adr_o(wb_adr_o), .wb_sel_o(wb_sel_o),
    .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
    .wb_err_i(wb_err_i)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic issue(input logic [34:0] c, input logic [31:0] d);
    chk1("rdy_before_push", phy_rdy_o, 1'b1);
    phy_vld_i  = 1'b1;
    phy_cmd_i  = c;
    phy_wdat_i = d;
    tick();
    phy_vld_i  = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "bench time limit");
  end

  initial begin
    reset_n = 1'b0; phy_vld_i = 1'b0; phy_cmd_i = '0; phy_wdat_i = '0;
    wb_dat_i = '0; wb_ack_i = 1'b0; wb_err_i = 1'b0;
    #3;
    chk1("rst_cyc", wb_cyc_o, 1'b0);
    chk1("rst_stb", wb_stb_o, 1'b0);
    chk1("rst_ack", phy_ack_o, 1'b0);
    chk1("rst_rdy", phy_rdy_o, 1'b0);
    chk32("rst_adr", wb_adr_o, 32'h0);
    tick(); tick();
    reset_n = 1'b1;
    tick();
    chk1("post_rst_rdy", phy_rdy_o, 1'b1);

    // 1: read, slave ack after 2 wait states
    issue(35'h0_0000_0010, 32'h0);
    chk1("rd_cyc_not_yet", wb_cyc_o, 1'b0);
    tick();
    chk1("rd_cyc", wb_cyc_o, 1'b1);
    chk1("rd_stb", wb_stb_o, 1'b1);
    chk32("rd_adr", wb_adr_o, 32'h40);
    chk32("rd_sel", {28'h0, wb_sel_o}, 32'hF);
    chk1("rd_we", wb_we_o, 1'b0);
    tick(); tick();
    chk1("rd_cyc_wait", wb_cyc_o, 1'b1);
    chk32("rd_adr_stable", wb_adr_o, 32'h40);
    wb_ack_i = 1'b1; wb_dat_i = 32'hCAFE_F00D;
    tick();
    wb_ack_i = 1'b0; wb_dat_i = 32'h0;
    chk1("rd_phy_ack", phy_ack_o, 1'b1);
    chk32("rd_rdat", phy_rdat_o, 32'hCAFE_F00D);
    chk1("rd_err", phy_err_o, 1'b0);
    chk1("rd_cyc_drop", wb_cyc_o, 1'b0);
    tick();
    chk1("rd_ack_one_cycle", phy_ack_o, 1'b0);
    chk32("rd_rdat_zero", phy_rdat_o, 32'h0);

    // 2: write with byte mask
    issue({1'b1, 4'b0101, 30'h3}, 32'h1122_3344);
    tick();
    chk1("wr_cyc", wb_cyc_o, 1'b1);
    chk1("wr_we", wb_we_o, 1'b1);
    chk32("wr_adr", wb_adr_o, 32'hC);
    chk32("wr_sel", {28'h0, wb_sel_o}, 32'h5);
    chk32("wr_dat", wb_dat_o, 32'h1122_3344);
    wb_ack_i = 1'b1;
    tick();
    wb_ack_i = 1'b0;
    chk1("wr_phy_ack", phy_ack_o, 1'b1);
    chk1("wr_err", phy_err_o, 1'b0);
    tick();
    chk1("wr_ack_one_cycle", phy_ack_o, 1'b0);

    // 3: back-pressure with stalled slave
    phy_vld_i = 1'b1; phy_cmd_i = 35'h100;
    tick();
    phy_cmd_i = 35'h101;
    tick();
    phy_cmd_i = 35'h102;
    tick();
    chk1("bp_rdy_low", phy_rdy_o, 1'b0);
    chk32("bp_adr_a", wb_adr_o, 32'h400);
    phy_cmd_i = 35'h103;
    tick(); tick();
    chk1("bp_rdy_still_low", phy_rdy_o, 1'b0);
    chk1("bp_cyc_held", wb_cyc_o, 1'b1);
    wb_ack_i = 1'b1; wb_dat_i = 32'hA1A1_A1A1;
    tick();
    wb_ack_i = 1'b0;
    chk1("bp_ack_a", phy_ack_o, 1'b1);
    chk32("bp_rdat_a", phy_rdat_o, 32'hA1A1_A1A1);
    chk1("bp_rdy_before_pop", phy_rdy_o, 1'b0);
    tick();
    chk1("bp_rdy_after_pop", phy_rdy_o, 1'b1);
    chk1("bp_cyc_b", wb_cyc_o, 1'b1);
    chk32("bp_adr_b", wb_adr_o, 32'h404);
    phy_vld_i = 1'b0;
    wb_ack_i = 1'b1; wb_dat_i = 32'hB1B1_B1B1;
    tick();
    wb_ack_i = 1'b0;
    chk32("bp_rdat_b", phy_rdat_o, 32'hB1B1_B1B1);
    tick();
    chk32("bp_adr_c", wb_adr_o, 32'h408);
    wb_ack_i = 1'b1; wb_dat_i = 32'hC1C1_C1C1;
    tick();
    wb_ack_i = 1'b0;
    chk32("bp_rdat_c", phy_rdat_o, 32'hC1C1_C1C1);
    tick();
    chk1("bp_idle_cyc", wb_cyc_o, 1'b0);
    tick();
    chk1("bp_d_not_taken", wb_cyc_o, 1'b0);

    // 4: ack and err together count as error; next command still issued
    phy_vld_i = 1'b1; phy_cmd_i = 35'h200;
    tick();
    phy_cmd_i = 35'h201;
    tick();
    phy_vld_i = 1'b0;
    chk32("ae_adr_e", wb_adr_o, 32'h800);
    wb_ack_i = 1'b1; wb_err_i = 1'b1; wb_dat_i = 32'h5555_5555;
    tick();
    wb_ack_i = 1'b0; wb_err_i = 1'b0;
    chk1("ae_phy_ack", phy_ack_o, 1'b1);
    chk1("ae_err", phy_err_o, 1'b1);
    tick();
    chk1("ae_cyc_f", wb_cyc_o, 1'b1);
    chk32("ae_adr_f", wb_adr_o, 32'h804);
    wb_ack_i = 1'b1; wb_dat_i = 32'h7777_7777;
    tick();
    wb_ack_i = 1'b0;
    chk1("ae_f_ack", phy_ack_o, 1'b1);
    chk1("ae_f_err", phy_err_o, 1'b0);
    chk32("ae_f_rdat", phy_rdat_o, 32'h7777_7777);
    tick();

    // 5: reset while a transaction is in flight and two commands queued
    phy_vld_i = 1'b1; phy_cmd_i = 35'h300;
    tick();
    phy_cmd_i = 35'h301;
    tick();
    phy_cmd_i = 35'h302;
    tick();
    phy_vld_i = 1'b0;
    chk1("mr_cyc_before", wb_cyc_o, 1'b1);
    chk1("mr_full", phy_rdy_o, 1'b0);
    #2;
    reset_n = 1'b0;
    #1;
    chk1("mr_cyc_async", wb_cyc_o, 1'b0);
    chk1("mr_stb_async", wb_stb_o, 1'b0);
    tick();
    reset_n = 1'b1;
    tick();
    chk1("mr_rdy", phy_rdy_o, 1'b1);
    ack_cnt = 0;
    for (int i = 0; i < 6; i++) begin
      if (phy_ack_o || wb_cyc_o) ack_cnt++;
      tick();
    end
    chk32("mr_no_activity", ack_cnt, 32'd0);

`ifdef CACHE_PHY_TIMEOUT_EN
    // 6: silent slave, watchdog ends the cycle after TO BUS cycles
    issue(35'h0_0000_0020, 32'h0);
    tick();
    for (int i = 1; i < TO; i++) begin
      chk1("to_cyc_held", wb_cyc_o, 1'b1);
      tick();
    end
    chk1("to_cyc_last", wb_cyc_o, 1'b1);
    tick();
    chk1("to_cyc_drop", wb_cyc_o, 1'b0);
    chk1("to_phy_ack", phy_ack_o, 1'b1);
    chk1("to_err", phy_err_o, 1'b1);
    chk32("to_rdat", phy_rdat_o, 32'hDEAD_BEEF);
    tick();
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
